// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of one 128-bit state per clock,
// MSB byte first, between a valid/ready input handshake and a valid/ready output handshake.
module inv_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int K  = 16 / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [127:0]    r_work;
  logic [127:0]    w_work_next;
  logic [127:0]    w_work_sub;
  logic [3:0]      w_base;
  logic [6:0]      w_lane_off [LANES];
  logic [7:0]      w_lane_in  [LANES];
  logic [7:0]      w_lane_out [LANES];

  // Byte index of the first lane is 15 - cnt*LANES; lane gi works one byte lower per step.
  assign w_base = 4'(r_cnt) * 4'(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane_off[gi] = {4'(15 - gi) - w_base, 3'b000};
    assign w_lane_in[gi]  = r_work[w_lane_off[gi] +: 8];
    assign w_lane_out[gi] = inv_sbox(w_lane_in[gi]);
  end

  always_comb begin
    w_work_sub = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_sub[w_lane_off[l] +: 8] = w_lane_out[l];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_work_next  = r_work;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_work_next  = in_data;
          w_cnt_next   = '0;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_work_next = w_work_sub;
        w_cnt_next  = r_cnt + CW'(1);
        if (r_cnt == CW'(K - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_work  <= w_work_next;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_work;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Scoreboard bench for inv_subbytes_seq: directed LANES=4 checks plus a forward/inverse
// round trip on every legal LANES value, using a forward S-box computed from GF(2^8).
`timescale 1ns/1ps
module tb_inv_subbytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rt_rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int n_spur   = 0;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];
  int unsigned  acc_q [$];
  logic         prev_valid = 1'b0;

  inv_subbytes_seq #(.LANES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input int x);
    logic [7:0] b, s;
    b = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] map_fwd(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwd_tab[d[i*8 +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] map_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[d[i*8 +: 8]];
    return r;
  endfunction

  // Inputs change at posedge+1; outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() > 0) check_val("latency_l4", 128'(cyc - acc_q.pop_front()), 128'd4);
        else n_spur++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check_val("data_l4", out_data, exp_q.pop_front());
          $display("l4 output %0d: %h", n_out, out_data);
        end else n_spur++;
        n_out++;
      end
    end
    prev_valid <= out_valid;
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e, output int unsigned acc);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    check_val("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    acc = cyc;
  endtask

  task automatic wait_outputs(input int target);
    int g = 0;
    while (n_out < target && g < 300) begin @(posedge clk); #1; g++; end
    check_val("out_count", 128'(n_out), 128'(target));
  endtask

  for (genvar gi = 0; gi < 5; gi++) begin : g_rt
    localparam int L  = 1 << gi;
    localparam int KK = 16 / L;
    logic         iv, ir, ov;
    logic [127:0] id, od;
    logic [127:0] q_exp [$];
    int unsigned  q_acc [$];
    logic         done = 1'b0;
    int           spur = 0;

    inv_subbytes_seq #(.LANES(L)) u_dut (
      .clk      (clk),
      .rst_n    (rt_rst_n),
      .in_valid (iv),
      .in_ready (ir),
      .in_data  (id),
      .out_valid(ov),
      .out_ready(1'b1),
      .out_data (od)
    );

    initial begin
      logic [127:0] x;
      int g;
      iv = 1'b0;
      id = '0;
      wait (rt_rst_n === 1'b1);
      @(posedge clk); #1;
      for (int n = 0; n < 1000; n++) begin
        x  = {$urandom, $urandom, $urandom, $urandom};
        iv = 1'b1;
        id = map_fwd(x);
        g  = 0;
        while (!ir && g < 100) begin @(posedge clk); #1; g++; end
        check_val($sformatf("rt_accept_L%0d", L), ir, 1'b1);
        @(posedge clk); #1;
        iv = 1'b0;
        q_exp.push_back(x);
        q_acc.push_back(cyc);
      end
      g = 0;
      while (q_exp.size() > 0 && g < 100) begin @(posedge clk); #1; g++; end
      check_val($sformatf("rt_drain_L%0d", L), 128'(q_exp.size()), 128'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (rt_rst_n && ov) begin
        if (q_exp.size() > 0) begin
          check_val($sformatf("rt_latency_L%0d", L), 128'(cyc - q_acc.pop_front()), 128'(KK));
          check_val($sformatf("rt_data_L%0d", L), od, q_exp.pop_front());
        end else spur++;
      end
    end
  end

  initial begin
    int unsigned a0, a1, a2;
    logic [127:0] d, held;
    int g;
    rst_n = 1'b0; rt_rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int x = 0; x < 256; x++) fwd_tab[x] = fwd_sbox(x);
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1; rt_rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vector: result appears exactly K=4 edges after accept and lasts one cycle.
    send({16{8'h63}}, 128'h0, a0);
    repeat (3) begin @(posedge clk); #1; end
    check_val("kv_not_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check_val("kv_valid_at_k", out_valid, 1'b1);
    check_val("kv_data", out_data, 128'h0);
    @(posedge clk); #1;
    check_val("kv_done_one_cycle", out_valid, 1'b0);
    check_val("kv_in_ready_back", in_ready, 1'b1);
    wait_outputs(1);

    send(128'h637c16ed_00000000_00000000_00000000, 128'h0001ff53_52525252_52525252_52525252, a0);
    wait_outputs(2);
    send(128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h52096ad5_3036a538_bf40a39e_81f3d7fb, a0);
    wait_outputs(3);

    // Backpressure: result must freeze while out_ready is low; an in_valid pulse is ignored.
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, map_inv(d), a0);
    g = 0;
    while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
    check_val("bp_valid", out_valid, 1'b1);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin in_valid = 1'b1; in_data = ~d; end
      if (i == 4) in_valid = 1'b0;
      check_val("bp_valid_hold", out_valid, 1'b1);
      check_val("bp_data_hold", out_data, held);
      check_val("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_valid", out_valid, 1'b0);
    check_val("bp_release_ready", in_ready, 1'b1);
    wait_outputs(4);

    // Abort: reset mid-BUSY clears everything asynchronously and the block never appears.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, map_inv(d), a0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", out_valid, 1'b0);
    check_val("abort_out_data", out_data, 128'h0);
    check_val("abort_in_ready", in_ready, 1'b1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check_val("abort_no_output", 128'(n_out), 128'd4);

    // Back-to-back: in_valid stays high, accepts spaced K+2 = 6 cycles apart.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, map_inv(d), a0);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, map_inv(d), a1);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, map_inv(d), a2);
    check_val("b2b_spacing_1", 128'(a1 - a0), 128'd6);
    check_val("b2b_spacing_2", 128'(a2 - a1), 128'd6);
    wait_outputs(7);

    g = 0;
    while (!(g_rt[0].done && g_rt[1].done && g_rt[2].done && g_rt[3].done && g_rt[4].done)
           && g < 40000) begin
      @(posedge clk); g++;
    end
    check_val("rt_all_done",
              {g_rt[4].done, g_rt[3].done, g_rt[2].done, g_rt[1].done, g_rt[0].done}, 5'b11111);
    check_val("spurious_outputs", 128'(n_spur), 128'd0);
    check_val("rt_spurious",
              128'(g_rt[0].spur + g_rt[1].spur + g_rt[2].spur + g_rt[3].spur + g_rt[4].spur), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
